// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT pipeline: widths, complex word
// layout, twiddle table, bit-reversal helper and the output-stage FSM states.
package fft_pkg;

   localparam int DW  = 32;   // Q16.16 component width
   localparam int NPT = 16;   // points per frame
   localparam int IW  = 4;    // index width for NPT points

   // Complex word, real part in the upper half: {real, imag}
   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   // Output-stage control states
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   // Twiddles W_k = exp(-j*2*pi*k/16) in Q16.16, shared by all stages
   localparam logic signed [DW-1:0] W_RE [8] = '{
      32'sd65536,  32'sd60547,  32'sd46341,  32'sd25080,
      32'sd0,     -32'sd25080, -32'sd46341, -32'sd60547
   };
   localparam logic signed [DW-1:0] W_IM [8] = '{
      32'sd0,     -32'sd25080, -32'sd46341, -32'sd60547,
     -32'sd65536, -32'sd60547, -32'sd46341, -32'sd25080
   };

   // Reverse the 4 index bits to map natural order onto butterfly order
   function automatic logic [IW-1:0] bitrev4(input logic [IW-1:0] x);
      return {x[0], x[1], x[2], x[3]};
   endfunction

endpackage

// File: rtl/fft_stage4_out_if.sv
// Frame-in / stream-out bus of the final FFT stage.
import fft_pkg::*;

interface fft_stage4_out_if;
   logic          in_valid;
   logic          in_ready;
   cplx_t         in_data [NPT];
   logic          out_valid;
   logic          out_ready;
   cplx_t         out_data;
   logic [IW-1:0] out_index;
   logic          frame_done;

   // Producer/consumer side (upstream stage 3 plus downstream sink)
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, frame_done
   );

   // The stage itself
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, frame_done
   );
endinterface

// File: rtl/fft_bf2.sv
// Combinational radix-2 butterfly with unity twiddle: a+b and a-b,
// real and imaginary parts independently, modular wrap on overflow.
import fft_pkg::*;

module fft_bf2 (
   input  cplx_t a_i,
   input  cplx_t b_i,
   output cplx_t sum_o,
   output cplx_t diff_o
);
   assign sum_o.re  = a_i.re + b_i.re;
   assign sum_o.im  = a_i.im + b_i.im;
   assign diff_o.re = a_i.re - b_i.re;
   assign diff_o.im = a_i.im - b_i.im;
endmodule

// File: rtl/fft_stage4_out.sv
// Last FFT stage: captures a parallel frame, applies the final butterfly
// layer on adjacent pairs, then streams the 16 bins in natural order.
import fft_pkg::*;

module fft_stage4_out (
   input  logic              clk,
   input  logic              rst_n,
   fft_stage4_out_if.slave   bus
);
   state_e        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          frame_done_q, frame_done_d;
   cplx_t         bank_q [NPT];
   cplx_t         bf_res [NPT];
   logic          capture;
   logic          beat;

   // Eight butterflies on pairs (2k, 2k+1)
   generate
      for (genvar gi = 0; gi < NPT/2; gi++) begin : g_bf
         fft_bf2 u_bf2 (
            .a_i    (bus.in_data[2*gi]),
            .b_i    (bus.in_data[2*gi+1]),
            .sum_o  (bf_res[2*gi]),
            .diff_o (bf_res[2*gi+1])
         );
      end
   endgenerate

   assign capture = (state_q == IDLE) && bus.in_valid;
   assign beat    = (state_q == STREAM) && bus.out_ready;

   // Next-state logic: capture moves to STREAM, last accepted beat returns to IDLE
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      if (capture) begin
         state_d = STREAM;
         cnt_d   = '0;
      end else if (beat) begin
         if (cnt_q == IW'(NPT-1)) begin
            state_d      = IDLE;
            cnt_d        = '0;
            frame_done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Result buffer: loaded only on capture, so input changes during STREAM are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NPT; i++) bank_q[i] <= '0;
      end else if (capture) begin
         for (int i = 0; i < NPT; i++) bank_q[i] <= bf_res[i];
      end
   end

   // Outputs decoded from registers only; data forced to zero outside STREAM
   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == STREAM);
   assign bus.out_index  = cnt_q;
   assign bus.out_data   = (state_q == STREAM) ? bank_q[bitrev4(cnt_q)] : '0;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_stage4_out.sv
// Directed self-checking bench for fft_stage4_out.
import fft_pkg::*;

module tb_fft_stage4_out;
   logic clk;
   logic rst_n;
   int   checks_cnt;
   int   errors_cnt;
   logic [63:0] exp_q [16];

   fft_stage4_out_if bus ();

   fft_stage4_out dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic zero_inputs();
      for (int i = 0; i < 16; i++) bus.in_data[i] = '0;
   endtask

   // kind 0: impulse, 1: mixed pair, 2: overflow wrap
   task automatic load_frame(input int kind);
      zero_inputs();
      for (int i = 0; i < 16; i++) exp_q[i] = '0;
      case (kind)
         0: begin
            bus.in_data[0] = {32'h0001_0000, 32'h0};
            exp_q[0] = {32'h0001_0000, 32'h0};
            exp_q[8] = {32'h0001_0000, 32'h0};
         end
         1: begin
            bus.in_data[2] = {32'h0, 32'h0002_0000};
            bus.in_data[3] = {32'h0001_0000, 32'h0};
            exp_q[4]  = {32'h0001_0000, 32'h0002_0000};
            exp_q[12] = {32'hFFFF_0000, 32'h0002_0000};
         end
         default: begin
            bus.in_data[0] = {32'h7FFF_0000, 32'h0};
            bus.in_data[1] = {32'h0002_0000, 32'h0};
            exp_q[0] = {32'h8001_0000, 32'h0};
            exp_q[8] = {32'h7FFD_0000, 32'h0};
         end
      endcase
   endtask

   // Present a frame for one edge; returns at the negedge after capture
   task automatic send_frame(input int kind);
      check_val("in_ready_idle", {63'h0, bus.in_ready}, 64'h1);
      load_frame(kind);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      zero_inputs();
      @(negedge clk);
   endtask

   // Drain one frame; optional 3-cycle stall and optional ignored input pulse
   task automatic collect(input int stall_idx, input int ign_idx);
      int acc = 0;
      int guard = 0;
      bit stalled = 0;
      bit ign_active = 0;
      logic [63:0] held;
      check_val("latency_valid", {63'h0, bus.out_valid}, 64'h1);
      while (acc < 16 && guard < 100) begin
         if (ign_active) begin
            bus.in_valid = 1'b0;
            zero_inputs();
            ign_active = 0;
         end
         if (bus.out_valid) begin
            if (acc == stall_idx && !stalled) begin
               stalled = 1;
               held = bus.out_data;
               bus.out_ready = 1'b0;
               for (int s = 0; s < 3; s++) begin
                  @(negedge clk);
                  check_val("stall_index", {60'h0, bus.out_index}, 64'd5);
                  check_val("stall_data", bus.out_data, held);
               end
               bus.out_ready = 1'b1;
            end
            if (acc == ign_idx) begin
               for (int i = 0; i < 16; i++) bus.in_data[i] = 64'h1111_1111_2222_2222;
               bus.in_valid = 1'b1;
               ign_active = 1;
               check_val("ign_in_ready", {63'h0, bus.in_ready}, 64'h0);
            end
            check_val("beat_index", {60'h0, bus.out_index}, 64'(acc));
            check_val("beat_data", bus.out_data, exp_q[acc]);
            $display("beat %0d: index %0d data %h", acc, bus.out_index, bus.out_data);
            acc++;
         end
         @(negedge clk);
         guard++;
      end
      if (ign_active) begin
         bus.in_valid = 1'b0;
         zero_inputs();
      end
      check_val("beat_count", 64'(acc), 64'd16);
      check_val("frame_done_hi", {63'h0, bus.frame_done}, 64'h1);
      check_val("idle_valid", {63'h0, bus.out_valid}, 64'h0);
      check_val("idle_ready", {63'h0, bus.in_ready}, 64'h1);
      @(negedge clk);
      check_val("frame_done_lo", {63'h0, bus.frame_done}, 64'h0);
   endtask

   initial begin
      int guard;
      checks_cnt = 0;
      errors_cnt = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      zero_inputs();
      repeat (3) @(negedge clk);
      check_val("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check_val("rst_out_data", bus.out_data, 64'h0);
      check_val("rst_out_index", {60'h0, bus.out_index}, 64'h0);
      check_val("rst_frame_done", {63'h0, bus.frame_done}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Impulse
      send_frame(0);
      collect(-1, -1);
      // Mixed pair with back-pressure at index 5
      send_frame(1);
      collect(5, -1);
      // Overflow wrap with an ignored input pulse during streaming
      send_frame(2);
      collect(-1, 3);
      // Impulse again immediately after the previous frame
      send_frame(0);
      collect(-1, -1);

      // Reset asserted mid-stream at index 7
      send_frame(2);
      guard = 0;
      while (bus.out_index != 4'd7 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_val("reach_index7", {60'h0, bus.out_index}, 64'd7);
      rst_n = 1'b0;
      #1;
      check_val("midrst_valid", {63'h0, bus.out_valid}, 64'h0);
      check_val("midrst_data", bus.out_data, 64'h0);
      check_val("midrst_index", {60'h0, bus.out_index}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_val("postrst_no_done", {63'h0, bus.frame_done}, 64'h0);
         check_val("postrst_valid", {63'h0, bus.out_valid}, 64'h0);
      end
      send_frame(1);
      collect(-1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/fft_stage4_out.md
Name: fft_stage4_out

Overview:
- Final radix-2 stage of the 16-point FFT pipeline; sits directly downstream of stage 3.
- Accepts one 16-sample frame in parallel and computes the last butterfly layer on adjacent pairs (twiddle W0, so no multiplier).
- Buffers the 16 results and streams them out one per cycle in natural frequency order (bit-reversal reorder) over a valid/ready handshake.

Parameters:
- DW, 32, width of each real/imag component; Q16.16 two's complement; word layout {real, imag}, total 2*DW bits.
- NPT, 16, points per frame; fixed to 16 in this revision; index width 4.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  frame present on in_data0..15.
- in_ready  out  1  block can capture a frame this cycle.
- in_data0 .. in_data15  in  2*DW each  stage-3 results, {real[63:32], imag[31:0]}.
- out_valid  out  1  out_data/out_index hold a valid result.
- out_ready  in  1  downstream accepts the current beat.
- out_data  out  2*DW  X[out_index], {real, imag}.
- out_index  out  4  frequency bin 0..15 of out_data.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, all 16 buffer entries=0, out_valid=0, out_index=0, out_data=0, frame_done=0. in_ready=1 once rst_n is released.
- States: IDLE and STREAM. in_ready = (state==IDLE), decoded from registered state only. out_valid = (state==STREAM).
- IDLE: on in_valid && in_ready at edge N:
  - buf[2k] <= in[2k] + in[2k+1]; buf[2k+1] <= in[2k] - in[2k+1], for k=0..7, real and imag independently.
  - cnt <= 0; state <= STREAM.
  - First out_valid in cycle N+1, one cycle of latency.
- STREAM:
  - out_index = cnt; out_data = buf[bitrev4(cnt)], muxed from registers with no combinational path from inputs.
  - On out_valid && out_ready: if cnt==15, go to IDLE, cnt <= 0, frame_done <= 1 for one cycle; else cnt <= cnt+1.
- Back-pressure: while out_ready=0, cnt, out_data and out_index are held stable.
- in_valid during STREAM is ignored (in_ready=0) and the buffer is unchanged. No back-to-back overlap: the earliest next capture is the cycle after the last beat.
- Arithmetic: DW-bit signed add/subtract with modular wrap. No saturation, no scaling; the carry bit is discarded (e.g. 0x7FFF0000 + 0x00020000 = 0x80010000).
- Reset asserted mid-stream: outputs drop to their reset values immediately; the partial frame is discarded; no frame_done is issued.
- frame_done is registered, high exactly one cycle, coincident with the first IDLE cycle.

Decomposition:
- Shared package fft_pkg:
  - DW and NPT constants
  - complex word typedef {real, imag}
  - twiddle constants W0..W7 real/imag, moved there for all stages
  - bitrev4 function
  - state enum {IDLE, STREAM}
- Sub-module fft_bf2: combinational radix-2 butterfly (a+b, a-b on complex words), instantiated 8×. It is reusable by stages 1–3 later.

Test Plan:
- Impulse: in_data0={0x00010000,0}, all others 0, accepted at edge N -> out_valid from N+1; beats f=0 and f=8 = {0x00010000,0}; all 14 other bins 0; frame_done pulse after beat 15.
- Mixed pair: in_data2={0,0x00020000}, in_data3={0x00010000,0} -> f=4 gives {0x00010000,0x00020000}; f=12 gives {0xFFFF0000,0x00020000}; out_index 0..15 ascending.
- Overflow wrap: in_data0.real=0x7FFF0000, in_data1.real=0x00020000 -> f=0 real 0x80010000; f=8 real 0x7FFD0000.
- Back-pressure: drop out_ready for 3 cycles at out_index=5 -> out_index stays 5 and out_data is unchanged; the stream resumes with 6; the total frame still has 16 accepted beats.
- Ignored input: pulse in_valid with different data during STREAM -> in_ready=0, remaining beats match the first frame; the next frame is accepted only after frame_done.
- Reset mid-stream: rst_n=0 at out_index=7 -> out_valid=0 and out_data=0 immediately; after release in_ready=1, frame_done never pulses; a new frame then streams correctly from index 0.
